// File: rtl/teclado_varredura.sv
// 4x4 keypad scanner: drives one column low at a time, debounces a single-key press
// and strobes its calculator key code; multi-key presses are swallowed until released.
module teclado_varredura #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_presa
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX   = BW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] VARRE  = 2'd0;
  localparam logic [1:0] FILTRA = 2'd1;
  localparam logic [1:0] ACEITA = 2'd2;
  localparam logic [1:0] SOLTA  = 2'd3;

  logic [3:0]    lin_p0;
  logic [3:0]    lin_s;
  logic [1:0]    estado;
  logic [1:0]    col;
  logic [1:0]    col_prox;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb;
  logic [3:0]    padrao;
  logic          fim_dwell;
  logic          fim_deb;
  logic          tudo_alto;

  function automatic logic [3:0] drv(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  function automatic logic um_baixo(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [1:0] linha_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!v[i]) r = 2'(i);
    return r;
  endfunction

  // Keypad legend: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  function automatic logic [3:0] codigo(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'hF;
      4'd13: k = 4'h0;
      4'd14: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign col_prox  = col + 2'd1;
  assign fim_dwell = (dwell == DWELL_MAX);
  assign fim_deb   = (deb == DEB_MAX);
  assign tudo_alto = (lin_s == 4'hF);

  // Row pattern seen at the end of the dwell; only consulted in FILTRA/ACEITA.
  always_ff @(posedge clk)
    if (estado == VARRE && fim_dwell) padrao <= lin_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lin_p0       <= 4'hF;
      lin_s        <= 4'hF;
      estado       <= VARRE;
      col          <= 2'd0;
      colunas      <= 4'b1110;
      dwell        <= '0;
      deb          <= '0;
      tecla        <= 4'h0;
      tecla_valida <= 1'b0;
      tecla_presa  <= 1'b0;
    end else begin
      // stage p0 -> s: two-flop synchronizer for the asynchronous rows
      lin_p0       <= linhas;
      lin_s        <= lin_p0;
      tecla_valida <= 1'b0;
      case (estado)
        VARRE: begin
          if (fim_dwell) begin
            dwell <= '0;
            deb   <= '0;
            if (tudo_alto) begin
              col     <= col_prox;
              colunas <= drv(col_prox);
            end else if (um_baixo(lin_s)) begin
              estado <= FILTRA;
            end else begin
              estado      <= SOLTA;
              tecla_presa <= 1'b1;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        FILTRA: begin
          if (lin_s != padrao) begin
            estado  <= VARRE;
            col     <= col_prox;
            colunas <= drv(col_prox);
            dwell   <= '0;
            deb     <= '0;
          end else if (fim_deb) begin
            estado       <= ACEITA;
            deb          <= '0;
            tecla        <= codigo(linha_idx(padrao), col);
            tecla_valida <= 1'b1;
            tecla_presa  <= 1'b1;
          end else begin
            deb <= deb + 1'b1;
          end
        end
        ACEITA: begin
          estado <= SOLTA;
          deb    <= '0;
        end
        default: begin
          // Release needs DEBOUNCE_CYC consecutive all-high samples on the held column.
          if (!tudo_alto) begin
            deb <= '0;
          end else if (fim_deb) begin
            estado      <= VARRE;
            col         <= col_prox;
            colunas     <= drv(col_prox);
            dwell       <= '0;
            deb         <= '0;
            tecla_presa <= 1'b0;
          end else begin
            deb <= deb + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_teclado_varredura.sv
// Bench for teclado_varredura with a combinational keypad model driving linhas from colunas.
module tb_teclado_varredura;

  typedef struct {
    int         r;
    int         c;
    int         hold;
    logic [3:0] codigo;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  linhas;
  logic [3:0]  colunas;
  logic [3:0]  tecla;
  logic        tecla_valida;
  logic        tecla_presa;
  logic [15:0] pressed;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [3:0]  exp_q[$];
  obs_t        obs_q[$];
  vec_t        tab[9];

  teclado_varredura #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .linhas       (linhas),
    .colunas      (colunas),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .tecla_presa  (tecla_presa)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    linhas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (colunas[c] === 1'b0)) linhas[r] = 1'b0;
  end

  always @(negedge clk)
    if (tecla_valida === 1'b1) obs_q.push_back('{cyc, tecla});

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nome, act, expv);
    end
  endtask

  task automatic press(input int r, input int c, input string nome, output int t_col);
    logic [3:0] tgt;
    int n;
    tgt = 4'hF;
    tgt[c] = 1'b0;
    n = 0;
    while (colunas == tgt && n < 20) begin tick(1); n++; end
    pressed[r*4+c] = 1'b1;
    n = 0;
    while (colunas != tgt && n < 40) begin tick(1); n++; end
    check({nome, " column reached"}, colunas, tgt);
    t_col = cyc;
  endtask

  task automatic take_strobe(input string nome, input int bound, output int t);
    int n;
    obs_t o;
    logic [3:0] e;
    n = 0;
    t = -1;
    while (obs_q.size() == 0 && n < bound) begin tick(1); n++; end
    total++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    if (obs_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no strobe within %0d cycles, expected code %0h", nome, bound, e);
    end else begin
      o = obs_q.pop_front();
      t = o.cyc;
      if (o.code !== e) begin
        bad++;
        $display("FAIL %s: strobe code %0h, expected %0h", nome, o.code, e);
      end
    end
  endtask

  task automatic wait_presa(input logic v, input int bound, input string nome);
    int n;
    n = 0;
    while (tecla_presa !== v && n < bound) begin tick(1); n++; end
    check(nome, tecla_presa, v);
  endtask

  task automatic run_key(input vec_t v, input string nome);
    int t_col;
    int t;
    exp_q.push_back(v.codigo);
    press(v.r, v.c, nome, t_col);
    take_strobe({nome, " strobe"}, 40, t);
    if (t >= 0) check({nome, " latency"}, t - t_col, 12);
    tick(v.hold);
    check({nome, " held presa"}, tecla_presa, 1'b1);
    check({nome, " held tecla"}, tecla, v.codigo);
    pressed = '0;
    tick(6);
    check({nome, " release pending"}, tecla_presa, 1'b1);
    wait_presa(1'b0, 30, {nome, " released"});
    check({nome, " tecla holds"}, tecla, v.codigo);
    check({nome, " single strobe"}, obs_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_col;
    int t;
    logic [3:0] e;

    tab[0] = '{1, 1, 40, 4'h5};
    tab[1] = '{3, 0, 12, 4'hF};
    tab[2] = '{3, 2, 12, 4'hE};
    tab[3] = '{3, 3, 12, 4'hD};
    tab[4] = '{2, 3, 12, 4'hC};
    tab[5] = '{0, 0, 12, 4'h1};
    tab[6] = '{3, 1, 12, 4'h0};
    tab[7] = '{0, 3, 12, 4'hA};
    tab[8] = '{2, 2, 12, 4'h9};

    rst_n = 1'b0;
    pressed = '0;
    tick(3);
    check("reset colunas", colunas, 4'b1110);
    check("reset tecla", tecla, 4'h0);
    check("reset valida", tecla_valida, 1'b0);
    check("reset presa", tecla_presa, 1'b0);

    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      e = 4'hF;
      e[(j / 4) % 4] = 1'b0;
      check($sformatf("scan seq %0d", j), colunas, e);
      tick(1);
    end

    for (int i = 0; i < 9; i++)
      run_key(tab[i], $sformatf("key%0d", i));

    // Bounce on key 3 (r0,c2), then a stable press and a short release glitch
    for (int i = 0; i < 10; i++) begin
      pressed[2] = ~pressed[2];
      tick(3);
    end
    check("bounce no strobe", obs_q.size(), 0);
    exp_q.push_back(4'h3);
    pressed[2] = 1'b1;
    take_strobe("bounce stable", 60, t);
    tick(5);
    pressed[2] = 1'b0;
    tick(3);
    pressed[2] = 1'b1;
    tick(2);
    pressed[2] = 1'b0;
    tick(7);
    check("glitch restarts release", tecla_presa, 1'b1);
    wait_presa(1'b0, 30, "glitch released");
    check("glitch no second strobe", obs_q.size(), 0);
    check("glitch tecla", tecla, 4'h3);

    // Two rows on column 0
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    wait_presa(1'b1, 40, "multi presa");
    tick(20);
    check("multi held presa", tecla_presa, 1'b1);
    check("multi tecla kept", tecla, 4'h3);
    pressed = '0;
    tick(6);
    check("multi release pending", tecla_presa, 1'b1);
    wait_presa(1'b0, 30, "multi released");
    check("multi tecla after", tecla, 4'h3);
    check("multi no strobe", obs_q.size(), 0);

    // Reset in the middle of FILTRA with "5" held
    press(1, 1, "rst mid", t_col);
    tick(7);
    rst_n = 1'b0;
    tick(2);
    check("rst mid colunas", colunas, 4'b1110);
    check("rst mid presa", tecla_presa, 1'b0);
    check("rst mid tecla", tecla, 4'h0);
    check("rst mid no strobe", obs_q.size(), 0);
    exp_q.push_back(4'h5);
    rst_n = 1'b1;
    take_strobe("rst mid redetect", 60, t);
    pressed = '0;
    wait_presa(1'b0, 40, "rst mid released");
    check("rst mid single strobe", obs_q.size(), 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/teclado_varredura.md
# teclado_varredura

Scans the calculator's 4x4 matrix keypad, debounces it, and encodes each press as a 4-bit key code with a one-cycle valid strobe. It sits directly upstream of the output decoder, which consumes `{estado, tecla}` as its 6-bit input. Key codes are the decoder's encoding: digits 0–9 = value, A=1010, B(+)=1011, C(−)=1100, D(=)=1101, #(getM)=1110, *(setM)=1111.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column stays driven; must be ≥ 4.
- `DEBOUNCE_CYC`, 50000: consecutive stable cycles required to accept a press and to accept a release; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `linhas` in 4: keypad rows, pulled up, active-low, asynchronous to `clk`.
- `colunas` out 4: column drive, one-cold (exactly one bit low).
- `tecla` out 4: code of the last accepted key; holds until the next accepted key.
- `tecla_valida` out 1: one-cycle strobe, high in the cycle `tecla` takes a new value.
- `tecla_presa` out 1: high while an accepted or invalid press has not yet been released.

## Operation
- Layout, row r / column c: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. Column index c = position in the row, 0..3.
- `linhas` passes through a 2-flop synchronizer before any use (`lin_s`).
- States: VARRE, FILTRA, ACEITA, SOLTA.
- VARRE: drive column c low and count dwell cycles 0..SCAN_DIV-1. On the last dwell cycle, sample `lin_s`.
  - All high: advance c = (c+1) mod 4, wrapping 3 → 0.
  - Exactly one bit low: latch the pattern and go to FILTRA.
  - More than one bit low: go to SOLTA with no strobe (invalid multi-key).
- FILTRA: the column is held.
  - If `lin_s` differs from the latched pattern, return to VARRE and advance the column.
  - Otherwise increment the counter. When the counter reaches DEBOUNCE_CYC-1 with a stable pattern, go to ACEITA.
- ACEITA: lasts one cycle. Register `tecla` from (r,c), pulse `tecla_valida`, then go to SOLTA.
- SOLTA: the column is held.
  - The counter increments while `lin_s` is all high and clears to 0 on any low bit.
  - At DEBOUNCE_CYC-1, go to VARRE, advance the column, and restart dwell at 0.
- `tecla_presa` = 1 in ACEITA and SOLTA.
- Presses in other columns while in FILTRA or SOLTA are invisible; only the held column is observed.
- Counters are sized with $clog2 of their parameter. All counters clear on every state entry.

## Timing
- Reset values: `colunas`=1110, `tecla`=0000, `tecla_valida`=0, `tecla_presa`=0, state VARRE, c=0, counters 0, synchronizer flops 1111.
- Reset is synchronous. Asserting `rst_n` low mid-FILTRA or mid-SOLTA returns to the reset values on the next edge, with no strobe. A key still held after reset is re-detected as a new press.
- `colunas` is registered and changes on the edge after the last dwell cycle.
- Press latency: from the first VARRE sample that sees the key to the `tecla_valida` cycle is DEBOUNCE_CYC+1 cycles. Worst case from a stable press is 4·SCAN_DIV + 2 + DEBOUNCE_CYC + 1.
- Exactly one `tecla_valida` pulse per press, regardless of hold time. There is no auto-repeat.
- A bounce in FILTRA restarts the search from the next column; a glitch in SOLTA restarts the release count.

## Test plan
Benches use SCAN_DIV=4, DEBOUNCE_CYC=8.

- **Reset:** hold `rst_n`=0 for 3 cycles with `linhas`=1111 → `colunas`=1110, `tecla`=0, `tecla_valida`=0, `tecla_presa`=0. Release reset → `colunas` sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
- **Digit press:** press "5" (row 1 while column 1 is low) and hold 40 cycles → exactly one `tecla_valida` pulse with `tecla`=0101, 9 cycles after the sampling cycle; `tecla_presa` stays 1 until 8 release cycles after `linhas` returns to 1111.
- **Corner keys:** press * (r3,c0) → 1111; # (r3,c2) → 1110; D (r3,c3) → 1101; C (r2,c3) → 1100; each gives one strobe.
- **Bounce:** toggle row 0 on column 2 every 3 cycles for 30 cycles, then hold it stable → no strobe during bouncing; one strobe with `tecla`=0011 after it is stable; a release glitch of 2 low cycles does not produce a second strobe.
- **Multi-key:** press rows 0 and 1 together on column 0 → no strobe; `tecla_presa`=1 until both are released for 8 cycles; `tecla` keeps its previous value.
- **Reset mid-debounce:** assert `rst_n`=0 at cycle 4 of FILTRA → no strobe; after release with the key still held, one strobe follows normally.
